// File: rtl/rast_fb_writer.sv
// -----------------------------------------------------------------------------
// rast_fb_writer
//
// Last stage of the rasterizer in the DVI frame-buffer path. Takes the
// rasterizer's (x, y, color) pixel stream and turns each pixel into one
// linear word write on the frame-buffer memory port. The frame buffer is
// double-buffered: pixels always land in the back buffer, and front/back
// swap on the first display vblank rise after the rasterizer flags the end
// of a frame.
//
// Optional feature (compile-time macro FB_CLEAR_EN):
//   When defined, a CLEAR state fills the whole back buffer with CLEAR_COLOR
//   after reset and after every swap, before pixels are accepted again.
//   When undefined, the CLEAR state, its address counter and the
//   CLEAR_COLOR parameter are not built.
//
// Parameters:
//   H_RES, V_RES  active pixels per line / active lines per frame
//   ADDR_W        frame-buffer word address width (holds 2*H_RES*V_RES)
//   CLEAR_COLOR   clear-pass fill value (FB_CLEAR_EN builds only)
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   rast_pixel_rdy        in   pixel valid from the rasterizer
//   rast_color_input[2:0] in   pixel color
//   rast_width[9:0]       in   pixel x
//   rast_height[8:0]      in   pixel y
//   rast_done             in   last pixel of the frame (rides with a pixel)
//   read_rast_pixel_rdy   out  ready back to the rasterizer
//   vblank                in   display vertical blank, synchronous to clk
//   fb_wr_en/addr/data    out  registered memory write request
//   fb_wr_busy            in   memory stall; request consumed when en & !busy
//   fb_front_sel          out  buffer being scanned out (back = !front)
//   frame_count[7:0]      out  completed swaps, wraps at 256
//   oob_err               out  sticky: an out-of-range pixel was dropped
//
// Handshake: a pixel transfers in any cycle where rast_pixel_rdy=1 and
// read_rast_pixel_rdy=1. Ready depends only on registered state and the
// current fb_wr_busy, never on rast_pixel_rdy, so there is no
// combinational loop through the rasterizer.
// -----------------------------------------------------------------------------
module rast_fb_writer #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int ADDR_W = 20
`ifdef FB_CLEAR_EN
    ,
    parameter logic [2:0] CLEAR_COLOR = 3'd0
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rast_pixel_rdy,
    input  logic [2:0]        rast_color_input,
    input  logic [9:0]        rast_width,
    input  logic [8:0]        rast_height,
    input  logic              rast_done,
    output logic              read_rast_pixel_rdy,
    input  logic              vblank,
    output logic              fb_wr_en,
    output logic [ADDR_W-1:0] fb_wr_addr,
    output logic [2:0]        fb_wr_data,
    input  logic              fb_wr_busy,
    output logic              fb_front_sel,
    output logic [7:0]        frame_count,
    output logic              oob_err
);

    localparam logic [ADDR_W-1:0] FB_SIZE = ADDR_W'(H_RES * V_RES);

`ifdef FB_CLEAR_EN
    typedef enum logic [1:0] {
        ST_ACCEPT    = 2'd0,
        ST_SWAP_WAIT = 2'd1,
        ST_CLEAR     = 2'd2
    } state_t;
    localparam state_t RESET_STATE = ST_CLEAR;
`else
    typedef enum logic [1:0] {
        ST_ACCEPT    = 2'd0,
        ST_SWAP_WAIT = 2'd1
    } state_t;
    localparam state_t RESET_STATE = ST_ACCEPT;
`endif

    state_t            state_q, state_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [2:0]        wr_data_q, wr_data_d;
    logic              front_sel_q, front_sel_d;
    logic [7:0]        frame_count_q, frame_count_d;
    logic              oob_q, oob_d;
    logic              vblank_q, vblank_d;
`ifdef FB_CLEAR_EN
    logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
`endif

    logic              slot_free;
    logic              ready;
    logic              accept;
    logic              in_range;
    logic              vblank_rise;
    logic [ADDR_W-1:0] x_ext;
    logic [ADDR_W-1:0] y_ext;
    logic [ADDR_W-1:0] row_off;
    logic [ADDR_W-1:0] back_base;
    logic [ADDR_W-1:0] pix_addr;

    // The single write slot can take a new request if it is empty or if its
    // current request is being consumed this cycle.
    assign slot_free = !wr_en_q || !fb_wr_busy;

    // Ready is held low while rst_n is asserted so the port reads as idle
    // during reset regardless of the state register.
    assign ready  = rst_n && (state_q == ST_ACCEPT) && slot_free;
    assign accept = rast_pixel_rdy && ready;

    assign in_range    = (int'(rast_width) < H_RES) && (int'(rast_height) < V_RES);
    assign vblank_rise = vblank && !vblank_q;

    assign x_ext     = ADDR_W'(rast_width);
    assign y_ext     = ADDR_W'(rast_height);
    assign back_base = front_sel_q ? '0 : FB_SIZE;

    // Row offset y*H_RES. For the 640-wide display the multiply reduces to
    // two shifts and an add (640 = 512 + 128).
    generate
        if (H_RES == 640) begin : g_row_shift
            assign row_off = (y_ext << 9) + (y_ext << 7);
        end else begin : g_row_mult
            assign row_off = y_ext * ADDR_W'(H_RES);
        end
    endgenerate

    assign pix_addr = back_base + row_off + x_ext;

    always_comb begin
        state_d       = state_q;
        wr_en_d       = wr_en_q;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        front_sel_d   = front_sel_q;
        frame_count_d = frame_count_q;
        oob_d         = oob_q;
        vblank_d      = vblank;
`ifdef FB_CLEAR_EN
        clr_cnt_d     = clr_cnt_q;
`endif

        // Retire the outstanding request once memory takes it.
        if (wr_en_q && !fb_wr_busy) begin
            wr_en_d = 1'b0;
        end

        case (state_q)
            ST_ACCEPT: begin
                if (accept) begin
                    if (in_range) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = pix_addr;
                        wr_data_d = rast_color_input;
                    end else begin
                        oob_d = 1'b1;
                    end
                    // An out-of-range pixel still closes the frame.
                    if (rast_done) begin
                        state_d = ST_SWAP_WAIT;
                    end
                end
            end

            ST_SWAP_WAIT: begin
                // The swap needs the last back-buffer write already gone;
                // an edge seen while it is still queued is not retried.
                if (vblank_rise && !wr_en_q) begin
                    front_sel_d   = !front_sel_q;
                    frame_count_d = frame_count_q + 8'd1;
`ifdef FB_CLEAR_EN
                    clr_cnt_d     = '0;
                    state_d       = ST_CLEAR;
`else
                    state_d       = ST_ACCEPT;
`endif
                end
            end

`ifdef FB_CLEAR_EN
            ST_CLEAR: begin
                // back_base already reflects the post-swap roles here.
                if (slot_free) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = back_base + clr_cnt_q;
                    wr_data_d = CLEAR_COLOR;
                    if (clr_cnt_q == FB_SIZE - 1'b1) begin
                        state_d = ST_ACCEPT;
                    end else begin
                        clr_cnt_d = clr_cnt_q + 1'b1;
                    end
                end
            end
`endif

            default: begin
                state_d = ST_ACCEPT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= RESET_STATE;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= 3'd0;
            front_sel_q   <= 1'b0;
            frame_count_q <= 8'd0;
            oob_q         <= 1'b0;
            vblank_q      <= 1'b0;
`ifdef FB_CLEAR_EN
            clr_cnt_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            front_sel_q   <= front_sel_d;
            frame_count_q <= frame_count_d;
            oob_q         <= oob_d;
            vblank_q      <= vblank_d;
`ifdef FB_CLEAR_EN
            clr_cnt_q     <= clr_cnt_d;
`endif
        end
    end

    assign read_rast_pixel_rdy = ready;
    assign fb_wr_en            = wr_en_q;
    assign fb_wr_addr          = wr_addr_q;
    assign fb_wr_data          = wr_data_q;
    assign fb_front_sel        = front_sel_q;
    assign frame_count         = frame_count_q;
    assign oob_err             = oob_q;

endmodule

// File: tb/tb_rast_fb_writer.sv
// -----------------------------------------------------------------------------
// Testbench for rast_fb_writer on a small 8x4 frame buffer.
// Stimulus tasks drive pixels; each accepted pixel's expected memory write
// is pushed into exp_q by a reference model that works from buffer roles
// and plain x/y arithmetic. A forked monitor pops and compares on every
// consumed write. Directed checks cover reset, latency, stall, swap, missed
// vblank edge, out-of-range pixels, mid-frame reset and frame_count wrap.
// -----------------------------------------------------------------------------
module tb_rast_fb_writer;

    localparam int H_RES   = 8;
    localparam int V_RES   = 4;
    localparam int ADDR_W  = 20;
    localparam int FB_SIZE = H_RES * V_RES;
    localparam logic [2:0] CLEAR_COLOR = 3'd0;

    logic              clk;
    logic              rst_n;
    logic              rast_pixel_rdy;
    logic [2:0]        rast_color_input;
    logic [9:0]        rast_width;
    logic [8:0]        rast_height;
    logic              rast_done;
    logic              read_rast_pixel_rdy;
    logic              vblank;
    logic              fb_wr_en;
    logic [ADDR_W-1:0] fb_wr_addr;
    logic [2:0]        fb_wr_data;
    logic              fb_wr_busy;
    logic              fb_front_sel;
    logic [7:0]        frame_count;
    logic              oob_err;

    rast_fb_writer #(
        .H_RES (H_RES),
        .V_RES (V_RES),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .rast_pixel_rdy     (rast_pixel_rdy),
        .rast_color_input   (rast_color_input),
        .rast_width         (rast_width),
        .rast_height        (rast_height),
        .rast_done          (rast_done),
        .read_rast_pixel_rdy(read_rast_pixel_rdy),
        .vblank             (vblank),
        .fb_wr_en           (fb_wr_en),
        .fb_wr_addr         (fb_wr_addr),
        .fb_wr_data         (fb_wr_data),
        .fb_wr_busy         (fb_wr_busy),
        .fb_front_sel       (fb_front_sel),
        .frame_count        (frame_count),
        .oob_err            (oob_err)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- memory stall driver ----------------
    // busy_mode: 0 = never busy, 1 = random, 2 = always busy.
    // Applied 2 time units after each edge so a mode set at +1 takes effect
    // in the same cycle.
    int busy_mode = 0;
    initial begin
        fb_wr_busy = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (busy_mode == 1)      fb_wr_busy = ($urandom_range(0, 3) == 0);
            else if (busy_mode == 2) fb_wr_busy = 1'b1;
            else                     fb_wr_busy = 1'b0;
        end
    end

    // ---------------- scoreboard / model state ----------------
    logic [ADDR_W+2:0] exp_q[$];
    int   total = 0;
    int   bad   = 0;
    logic model_front = 1'b0;
    int   model_fc    = 0;
    logic model_oob   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, exp);
        end
    endtask

    task automatic monitor();
        logic [ADDR_W+2:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && fb_wr_en && !fb_wr_busy) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL wr_unexpected addr=%0d data=%0d want=none", fb_wr_addr, fb_wr_data);
                end else begin
                    e = exp_q.pop_front();
                    if ({fb_wr_addr, fb_wr_data} !== e) begin
                        bad++;
                        $display("FAIL wr_check addr=%0d data=%0d want addr=%0d data=%0d",
                                 fb_wr_addr, fb_wr_data, e[ADDR_W+2:3], e[2:0]);
                    end
                end
            end
        end
    endtask

    // Model of one accepted pixel: where it must land, or that it is dropped.
    task automatic model_accept(input int x, input int y, input logic [2:0] c);
        int base;
        base = model_front ? 0 : FB_SIZE;
        if (x < H_RES && y < V_RES) begin
            exp_q.push_back({ADDR_W'(base + y * H_RES + x), c});
        end else begin
            model_oob = 1'b1;
        end
    endtask

    task automatic push_clear();
        int base;
        base = model_front ? 0 : FB_SIZE;
        for (int i = 0; i < FB_SIZE; i++) begin
            exp_q.push_back({ADDR_W'(base + i), CLEAR_COLOR});
        end
    endtask

    // ---------------- driver tasks (entered at posedge+1) ----------------
    task automatic send_pixel(input int x, input int y, input logic [2:0] c, input logic done);
        int   waited;
        logic acc;
        waited = 0;
        acc    = 1'b0;
        rast_width       = 10'(x);
        rast_height      = 9'(y);
        rast_color_input = c;
        rast_done        = done;
        rast_pixel_rdy   = 1'b1;
        while (!acc) begin
            @(negedge clk);
            if (read_rast_pixel_rdy) begin
                acc = 1'b1;
                model_accept(x, y, c);
            end else if (waited > 1000) begin
                total++;
                bad++;
                $display("FAIL accept_timeout x=%0d y=%0d got=no_ready want=ready", x, y);
                acc = 1'b1;
            end
            waited++;
            @(posedge clk);
            #1;
        end
        rast_pixel_rdy = 1'b0;
        rast_done      = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(exp_q.size() == 0 && !fb_wr_en) && n < 2000);
        if (n >= 2000) begin
            total++;
            bad++;
            $display("FAIL idle_timeout pending=%0d want=0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    // Called after a done pixel was accepted: drain, raise vblank, check swap.
    task automatic do_swap();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            chk("swap_wait_rdy", 32'(read_rast_pixel_rdy), 32'd0);
            n++;
        end while (!(exp_q.size() == 0 && !fb_wr_en) && n < 2000);
        if (n >= 2000) begin
            total++;
            bad++;
            $display("FAIL drain_timeout pending=%0d want=0", exp_q.size());
        end
        @(posedge clk);
        #1;
        vblank      = 1'b1;
        model_front = !model_front;
        model_fc    = (model_fc + 1) % 256;
        @(posedge clk);
        #1;
        vblank = 1'b0;
        chk("swap_front", 32'(fb_front_sel), 32'(model_front));
        chk("swap_count", 32'(frame_count), 32'(model_fc));
`ifdef FB_CLEAR_EN
        push_clear();
`else
        @(negedge clk);
        chk("post_swap_rdy", 32'(read_rast_pixel_rdy), 32'd1);
        @(posedge clk);
        #1;
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rdy"},   32'(read_rast_pixel_rdy), 32'd0);
        chk({tag, "_en"},    32'(fb_wr_en),     32'd0);
        chk({tag, "_addr"},  32'(fb_wr_addr),   32'd0);
        chk({tag, "_data"},  32'(fb_wr_data),   32'd0);
        chk({tag, "_front"}, 32'(fb_front_sel), 32'd0);
        chk({tag, "_count"}, 32'(frame_count),  32'd0);
        chk({tag, "_oob"},   32'(oob_err),      32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [ADDR_W-1:0] held_addr;
        logic [2:0]        held_data;

        rst_n            = 1'b0;
        rast_pixel_rdy   = 1'b0;
        rast_color_input = 3'd0;
        rast_width       = 10'd0;
        rast_height      = 9'd0;
        rast_done        = 1'b0;
        vblank           = 1'b0;
        fork
            monitor();
        join_none

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_n = 1'b1;
`ifdef FB_CLEAR_EN
        push_clear();
`endif

        // basic write: x=3 y=2 -> back buffer base 32 + 2*8 + 3 = 51
        send_pixel(3, 2, 3'd5, 1'b0);
        chk("basic_en",   32'(fb_wr_en),   32'd1);
        chk("basic_addr", 32'(fb_wr_addr), 32'd51);
        chk("basic_data", 32'(fb_wr_data), 32'd5);

        // backpressure: write held for 3 stalled cycles
        wait_idle();
        busy_mode = 2;
        send_pixel(6, 1, 3'd2, 1'b0);
        held_addr = ADDR_W'(FB_SIZE + 1 * H_RES + 6);
        held_data = 3'd2;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_rdy",  32'(read_rast_pixel_rdy), 32'd0);
            chk("stall_en",   32'(fb_wr_en),   32'd1);
            chk("stall_addr", 32'(fb_wr_addr), 32'(held_addr));
            chk("stall_data", 32'(fb_wr_data), 32'(held_data));
        end
        @(posedge clk);
        #1;
        busy_mode = 0;
        @(negedge clk);
        chk("unstall_rdy", 32'(read_rast_pixel_rdy), 32'd1);
        @(posedge clk);
        #1;

        // out of range: no write, sticky flag
        chk("oob_before", 32'(oob_err), 32'd0);
        send_pixel(8, 0, 3'd7, 1'b0);
        send_pixel(0, 4, 3'd1, 1'b0);
        @(negedge clk);
        chk("oob_set", 32'(oob_err), 32'(model_oob));
        @(posedge clk);
        #1;

        // swap: done pixel, vblank 10+ cycles later
        send_pixel(7, 3, 3'd2, 1'b1);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("done_wait_rdy", 32'(read_rast_pixel_rdy), 32'd0);
        end
        @(posedge clk);
        #1;
        do_swap();
        send_pixel(1, 0, 3'd4, 1'b0);   // now lands at base 0
        chk("front_base_addr", 32'(fb_wr_addr), 32'd1);

        // vblank edge while the last write is pending is missed
        wait_idle();
        busy_mode = 2;
        send_pixel(1, 1, 3'd3, 1'b1);
        vblank = 1'b1;
        @(posedge clk);
        #1;
        vblank = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("missed_edge_front", 32'(fb_front_sel), 32'(model_front));
        chk("missed_edge_count", 32'(frame_count),  32'(model_fc));
        busy_mode = 0;
        do_swap();

        // randomized traffic with random stalls and frames
        busy_mode = 1;
        for (int i = 0; i < 200; i++) begin
            int   x;
            int   y;
            logic d;
            x = $urandom_range(0, H_RES + 1);
            y = $urandom_range(0, V_RES);
            d = ($urandom_range(0, 15) == 0);
            send_pixel(x, y, 3'($urandom_range(0, 7)), d);
            if (d) do_swap();
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
        send_pixel(2, 2, 3'd6, 1'b1);
        do_swap();
        chk("oob_sticky", 32'(oob_err), 32'(model_oob));

        // frame_count wrap: 256 more swaps returns to the same count
        busy_mode = 0;
        for (int i = 0; i < 256; i++) begin
            send_pixel($urandom_range(0, H_RES - 1), $urandom_range(0, V_RES - 1),
                       3'($urandom_range(0, 7)), 1'b1);
            do_swap();
        end

        // reset mid-frame with a write pending (front buffer = 1 first)
        if (!model_front) begin
            send_pixel(0, 0, 3'd1, 1'b1);
            do_swap();
        end
        wait_idle();
        chk("pre_reset_front", 32'(fb_front_sel), 32'd1);
        busy_mode = 2;
        send_pixel(2, 1, 3'd6, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("midreset");
        rst_n = 1'b1;
        exp_q.delete();
        model_front = 1'b0;
        model_fc    = 0;
        model_oob   = 1'b0;
        busy_mode   = 0;
`ifdef FB_CLEAR_EN
        push_clear();
`endif
        send_pixel(3, 2, 3'd5, 1'b0);
        chk("post_reset_addr", 32'(fb_wr_addr), 32'd51);
        wait_idle();
        chk("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time bound so the run always ends.
    initial begin
        #2000000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "global timeout");
    end

endmodule
